fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: PC value loaded on reset.
REQ-002 Parameter NOP_INSTR, default 32'h0000_0000: encoding inserted into IF/ID on bubble or flush.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 PCWr  input  1  hazard unit PC write enable; 0 = stall PC.
REQ-006 IFIDWr  input  1  hazard unit IF/ID write enable; 0 = hold IF/ID.
REQ-007 flush  input  1  branch/jump taken in ID; redirect and squash.
REQ-008 branchTarget  input  32  redirect PC, sampled when flush=1.
REQ-009 imemReq  output  1  instruction memory request.
REQ-010 imemAddr  output  32  fetch address, equals PC.
REQ-011 imemRdata  input  32  instruction word, valid when imemReady=1.
REQ-012 imemReady  input  1  memory accepts request and returns data this cycle.
REQ-013 PC  output  32  current fetch PC.
REQ-014 IFIDInstr  output  32  registered instruction to ID.
REQ-015 IFIDPCPlus4  output  32  registered PC+4 of that instruction.
REQ-016 IFIDValid  output  1  1 = IFIDInstr is a real instruction, 0 = bubble.

Function
REQ-017 advance = PCWr & IFIDWr; either low is a stall.
REQ-018 FSM states: IDLE, REQ, WAIT, HELD, DROP; imemReq=1 in REQ, WAIT, DROP only.
REQ-019 imemAddr and PC stay stable while imemReq=1 and imemReady=0.
REQ-020 IDLE -> REQ unconditionally on the first edge after reset release.
REQ-021 REQ/WAIT, imemReady=1, advance=1, flush=0: IF/ID <= {imemRdata, PC+4, valid 1}; PC <= PC+4; next REQ (zero-wait memory sustains one instruction per cycle, one-cycle latency).
REQ-022 REQ/WAIT, imemReady=1, advance=0, flush=0: imemRdata captured in holding buffer; IF/ID and PC unchanged; next HELD.
REQ-023 REQ/WAIT, imemReady=0, flush=0: next WAIT; if IFIDWr=1, IF/ID <= {NOP_INSTR, IFIDPCPlus4 unchanged, valid 0}; else IF/ID held.
REQ-024 HELD, imemReq=0: when advance=1, IF/ID <= {buffer, PC+4, valid 1}; PC <= PC+4; next REQ; else stay HELD.
REQ-025 flush=1 has priority over stall and fetch completion in every state except IDLE: IF/ID <= {NOP_INSTR, 0, valid 0}; PC <= branchTarget; holding buffer discarded.
REQ-026 Flush in REQ/WAIT with imemReady=1, or in HELD: next REQ at branchTarget.
REQ-027 Flush in REQ/WAIT with imemReady=0: next DROP; request completes at the old address held in an internal register while PC shows branchTarget.
REQ-028 DROP: imemAddr = saved old address; on imemReady=1 data discarded, next REQ; IF/ID receives bubbles while IFIDWr=1; a further flush in DROP updates PC only.
REQ-029 PC+4 is modulo 2^32; 32'hFFFF_FFFC wraps to 32'h0000_0000.

Reset
REQ-030 rst_n=0 asynchronously forces state IDLE, PC=RESET_PC, IFIDInstr=NOP_INSTR, IFIDPCPlus4=0, IFIDValid=0, holding buffer=0, imemReq=0.
REQ-031 Reset asserted mid-fetch abandons the request; no handshake completion is required.

Structure
REQ-032 FSM state encoding and NOP_INSTR default SHALL live in the shared pipeline package, used also by the hazard unit and ID/EX register.
REQ-033 The IF/ID register (instr, PC+4, valid, write enable, flush) SHALL be a sub-module if_id_reg; FSM, PC and holding buffer stay in fetch_stage.

Verification
REQ-034 Reset release, imemReady tied 1, rdata=PC: IFIDInstr = 0,4,8 on cycles 2,3,4, IFIDValid=1.
REQ-035 Steady stream, PCWr=IFIDWr=0 for 1 cycle at PC=0x10: IF/ID holds instr from 0x0C, enters HELD, releases 0x10 next cycle, no loss or duplicate.
REQ-036 imemReady low 3 cycles at PC=0x20, IFIDWr=1: 3 bubbles (IFIDValid=0, IFIDInstr=NOP), then 0x20 delivered.
REQ-037 flush with branchTarget=0x100 while WAIT at 0x40: DROP until ready, 0x40 data never reaches IF/ID, next delivered instruction from 0x100.
REQ-038 flush and stall same cycle in HELD: IF/ID=bubble, PC=branchTarget, buffer discarded.
REQ-039 rst_n pulse low mid-WAIT: all outputs at reset values immediately, imemReq=0; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/pipeline_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_pkg
// Shared pipeline definitions used by the fetch stage, hazard unit and the
// ID/EX register: fetch FSM state encoding, the IF/ID payload structure, the
// default NOP encoding and a PC increment helper.
// No ports (package).
// -----------------------------------------------------------------------------
package pipeline_pkg;

  localparam int unsigned XLEN = 32;

  // Encoding used for bubbles unless a stage overrides it by parameter.
  localparam logic [XLEN-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  // Fetch sequencer states.
  //   IDLE : one cycle after reset release, no request
  //   REQ  : request issued at PC
  //   WAIT : request at PC still outstanding (memory not ready)
  //   HELD : instruction fetched during a stall, parked in the holding buffer
  //   DROP : request at a stale address being completed after a redirect
  typedef enum logic [2:0] {
    FETCH_IDLE = 3'd0,
    FETCH_REQ  = 3'd1,
    FETCH_WAIT = 3'd2,
    FETCH_HELD = 3'd3,
    FETCH_DROP = 3'd4
  } fetch_state_e;

  // Contents of the IF/ID pipeline register.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_plus4;
    logic            valid;
  } if_id_t;

  // Sequential PC step; wraps modulo 2^32.
  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register. Flush forces a bubble {NOP, 0, invalid} and wins
// over the write enable; otherwise the register loads d when we=1 and holds
// when we=0.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   we         : write enable (0 = hold)
//   flush      : squash contents to a bubble
//   d          : next IF/ID payload
//   q          : current IF/ID payload
// -----------------------------------------------------------------------------
module if_id_reg
  import pipeline_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   we,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its inputs from the same pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
    end else if (flush) begin
      q <= '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};
    end else if (we) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch stage: owns the PC, the fetch request sequencer and a
// one-entry holding buffer for instructions returned while the pipeline is
// stalled. Feeds the IF/ID register (if_id_reg).
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   PCWr, IFIDWr  : hazard-unit write enables; either low stalls fetch
//   flush         : taken branch/jump in ID; redirect to branchTarget
//   branchTarget  : redirect address, sampled when flush=1
//   imemReq       : instruction memory request
//   imemAddr      : request address (PC, or the stale address in DROP)
//   imemRdata     : instruction word, valid with imemReady
//   imemReady     : memory completes the request this cycle
//   PC            : current fetch PC
//   IFIDInstr, IFIDPCPlus4, IFIDValid : IF/ID register outputs
// -----------------------------------------------------------------------------
module fetch_stage
  import pipeline_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        PCWr,
  input  logic        IFIDWr,
  input  logic        flush,
  input  logic [31:0] branchTarget,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic [31:0] imemRdata,
  input  logic        imemReady,
  output logic [31:0] PC,
  output logic [31:0] IFIDInstr,
  output logic [31:0] IFIDPCPlus4,
  output logic        IFIDValid
);

  fetch_state_e state, state_next;
  logic [31:0]  pc_q, pc_next;
  logic [31:0]  held_instr, held_next;
  logic [31:0]  drop_addr, drop_next;
  logic [31:0]  pc_plus4;
  logic         advance;
  logic         flush_act;
  logic         ifid_we;
  logic         ifid_flush;
  if_id_t       ifid_d;
  if_id_t       ifid_q;

  assign advance   = PCWr & IFIDWr;
  assign pc_plus4  = pc_inc(pc_q);
  // A redirect arriving before the first request is meaningless; ignore it.
  assign flush_act = flush & (state != FETCH_IDLE);

  // ---------------------------------------------------------------------------
  // Next-state and datapath control
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_next = state;
    pc_next    = pc_q;
    held_next  = held_instr;
    drop_next  = drop_addr;
    ifid_we    = 1'b0;
    ifid_flush = flush_act;
    // Default payload is a bubble that keeps the previous PC+4.
    ifid_d     = '{instr: NOP_INSTR, pc_plus4: ifid_q.pc_plus4, valid: 1'b0};

    unique case (state)
      FETCH_IDLE: begin
        state_next = FETCH_REQ;
      end

      FETCH_REQ, FETCH_WAIT: begin
        if (flush_act) begin
          pc_next   = branchTarget;
          held_next = '0;
          if (imemReady) begin
            state_next = FETCH_REQ;
          end else begin
            // The outstanding request must finish at its original address.
            drop_next  = pc_q;
            state_next = FETCH_DROP;
          end
        end else if (imemReady) begin
          if (advance) begin
            ifid_we    = 1'b1;
            ifid_d     = '{instr: imemRdata, pc_plus4: pc_plus4, valid: 1'b1};
            pc_next    = pc_plus4;
            state_next = FETCH_REQ;
          end else begin
            held_next  = imemRdata;
            state_next = FETCH_HELD;
          end
        end else begin
          ifid_we    = IFIDWr;
          state_next = FETCH_WAIT;
        end
      end

      FETCH_HELD: begin
        if (flush_act) begin
          pc_next    = branchTarget;
          held_next  = '0;
          state_next = FETCH_REQ;
        end else if (advance) begin
          ifid_we    = 1'b1;
          ifid_d     = '{instr: held_instr, pc_plus4: pc_plus4, valid: 1'b1};
          pc_next    = pc_plus4;
          state_next = FETCH_REQ;
        end
      end

      FETCH_DROP: begin
        // Data returned here belongs to the squashed path and is discarded.
        ifid_we = IFIDWr;
        if (flush_act) begin
          pc_next = branchTarget;
        end
        if (imemReady) begin
          state_next = FETCH_REQ;
        end
      end

      default: begin
        state_next = FETCH_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: the holding buffer and drop address are ordinary registers, not a
  // memory array, so they are reset along with the rest of the state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH_IDLE;
      pc_q       <= RESET_PC;
      held_instr <= '0;
      drop_addr  <= '0;
    end else begin
      state      <= state_next;
      pc_q       <= pc_next;
      held_instr <= held_next;
      drop_addr  <= drop_next;
    end
  end

  // ---------------------------------------------------------------------------
  // IF/ID register
  // ---------------------------------------------------------------------------
  if_id_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (ifid_we),
    .flush (ifid_flush),
    .d     (ifid_d),
    .q     (ifid_q)
  );

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign imemReq     = (state == FETCH_REQ) || (state == FETCH_WAIT) ||
                       (state == FETCH_DROP);
  assign imemAddr    = (state == FETCH_DROP) ? drop_addr : pc_q;
  assign PC          = pc_q;
  assign IFIDInstr   = ifid_q.instr;
  assign IFIDPCPlus4 = ifid_q.pc_plus4;
  assign IFIDValid   = ifid_q.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Directed bench for fetch_stage. The memory model returns the request
// address as the instruction word, so every delivered instruction identifies
// the address it was fetched from. A non-zero NOP encoding keeps bubbles
// distinguishable from the instruction at address 0.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst_n;
  logic        PCWr;
  logic        IFIDWr;
  logic        flush;
  logic [31:0] branchTarget;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] imemRdata;
  logic        imemReady;
  logic [31:0] PC;
  logic [31:0] IFIDInstr;
  logic [31:0] IFIDPCPlus4;
  logic        IFIDValid;

  int          checks;
  int          errors;
  logic [31:0] exp_pc;

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (NOP)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .PCWr         (PCWr),
    .IFIDWr       (IFIDWr),
    .flush        (flush),
    .branchTarget (branchTarget),
    .imemReq      (imemReq),
    .imemAddr     (imemAddr),
    .imemRdata    (imemRdata),
    .imemReady    (imemReady),
    .PC           (PC),
    .IFIDInstr    (IFIDInstr),
    .IFIDPCPlus4  (IFIDPCPlus4),
    .IFIDValid    (IFIDValid)
  );

  assign imemRdata = imemAddr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Compare the full visible state of the stage against expectations.
  task automatic expect_all(input string tag, input logic [31:0] e_instr,
                            input logic [31:0] e_pcp4, input logic e_valid,
                            input logic [31:0] e_pc, input logic e_req,
                            input logic [31:0] e_addr);
    check({tag, ".instr"}, IFIDInstr, e_instr);
    check({tag, ".pcp4"},  IFIDPCPlus4, e_pcp4);
    check({tag, ".valid"}, {31'd0, IFIDValid}, {31'd0, e_valid});
    check({tag, ".pc"},    PC, e_pc);
    check({tag, ".req"},   {31'd0, imemReq}, {31'd0, e_req});
    check({tag, ".addr"},  imemAddr, e_addr);
  endtask

  // Zero-wait streaming: one instruction delivered per cycle from exp_pc.
  task automatic stream(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      expect_all($sformatf("%s%0d", tag, i), exp_pc, exp_pc + 32'd4, 1'b1,
                 exp_pc + 32'd4, 1'b1, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    PCWr         = 1'b1;
    IFIDWr       = 1'b1;
    flush        = 1'b0;
    branchTarget = '0;
    imemReady    = 1'b1;

    // Reset values.
    @(negedge clk);
    expect_all("rst", NOP, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    rst_n = 1'b1;

    // First edge: IDLE -> REQ, nothing delivered yet.
    @(negedge clk);
    expect_all("idle2req", NOP, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);

    // Zero-wait stream: 0,4,8,C.
    exp_pc = 32'h0;
    stream("s0_", 4);

    // One-cycle stall at PC=0x10: instruction parked, IF/ID holds 0x0C.
    PCWr   = 1'b0;
    IFIDWr = 1'b0;
    @(negedge clk);
    expect_all("held", 32'h0C, 32'h10, 1'b1, 32'h10, 1'b0, 32'h10);
    PCWr   = 1'b1;
    IFIDWr = 1'b1;
    stream("s1_", 4);  // 0x10 released from buffer, then 0x14..0x1C

    // Memory not ready for 3 cycles at 0x20: three bubbles, PC+4 kept.
    imemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      expect_all($sformatf("wait%0d", i), NOP, 32'h20, 1'b0, 32'h20, 1'b1, 32'h20);
    end
    imemReady = 1'b1;
    stream("s2_", 8);  // 0x20..0x3C, PC now 0x40

    // Enter WAIT at 0x40, then flush to 0x100 while not ready.
    imemReady = 1'b0;
    @(negedge clk);
    expect_all("wait40", NOP, 32'h40, 1'b0, 32'h40, 1'b1, 32'h40);
    flush        = 1'b1;
    branchTarget = 32'h100;
    @(negedge clk);
    expect_all("drop0", NOP, 32'h0, 1'b0, 32'h100, 1'b1, 32'h40);
    flush        = 1'b0;
    @(negedge clk);
    expect_all("drop1", NOP, 32'h0, 1'b0, 32'h100, 1'b1, 32'h40);
    imemReady = 1'b1;
    @(negedge clk);  // stale 0x40 data returned and discarded
    expect_all("dropdone", NOP, 32'h0, 1'b0, 32'h100, 1'b1, 32'h100);
    exp_pc = 32'h100;
    stream("s3_", 3);  // 0x100,0x104,0x108

    // Stall into HELD at 0x10C, then flush and stall together.
    PCWr = 1'b0;
    @(negedge clk);
    expect_all("held2", 32'h108, 32'h10C, 1'b1, 32'h10C, 1'b0, 32'h10C);
    flush        = 1'b1;
    branchTarget = 32'h200;
    IFIDWr       = 1'b0;
    @(negedge clk);
    expect_all("heldflush", NOP, 32'h0, 1'b0, 32'h200, 1'b1, 32'h200);
    flush  = 1'b0;
    PCWr   = 1'b1;
    IFIDWr = 1'b1;
    exp_pc = 32'h200;
    stream("s4_", 2);  // 0x200 must follow, not the buffered 0x10C

    // Redirect to the top of the address space; PC+4 wraps to 0.
    flush        = 1'b1;
    branchTarget = 32'hFFFF_FFFC;
    @(negedge clk);
    expect_all("wrapflush", NOP, 32'h0, 1'b0, 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC);
    flush  = 1'b0;
    exp_pc = 32'hFFFF_FFFC;
    stream("wrap", 2);  // FFFFFFFC (pcp4 0), then 0; PC ends at 4

    // Asynchronous reset in the middle of a WAIT.
    imemReady = 1'b0;
    @(negedge clk);
    expect_all("wait4", NOP, 32'h4, 1'b0, 32'h4, 1'b1, 32'h4);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    expect_all("asyncrst", NOP, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    expect_all("rsthold", NOP, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    rst_n     = 1'b1;
    imemReady = 1'b1;
    @(negedge clk);
    expect_all("restart", NOP, 32'h0, 1'b0, 32'h0, 1'b1, 32'h0);
    exp_pc = 32'h0;
    stream("s5_", 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
